// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Word layout: {opcode[11:8], rs1[7:6], rs2[5:4], rd[3:2], ctrl[1:0]}.
package seq_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int WORD_W     = 12;
    localparam int ADDR_W     = 4;
    localparam int OP_W       = 4;
    localparam int SEL_W      = 2;
    localparam int WDOG_W     = 8;

    localparam int OP_LSB   = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 4;
    localparam int RD_LSB   = 2;
    localparam int CTRL_LSB = 0;
    localparam int TGT_LSB  = 4;

    // Last count seen before the watchdog fires on the 255th busy cycle.
    localparam logic [WDOG_W-1:0] WDOG_LAST = 8'd254;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_BR_WAIT = 2'd2,
        S_HALT    = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CTRL_NORMAL = 2'b00,
        CTRL_BZ     = 2'b01,
        CTRL_BC     = 2'b10,
        CTRL_HALT   = 2'b11
    } seq_ctrl_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SEL_W-1:0] rs1;
        logic [SEL_W-1:0] rs2;
        logic [SEL_W-1:0] rd;
        seq_ctrl_e        ctrl;
    } seq_word_t;

    // Branch target occupies word[7:4], i.e. the rs1/rs2 fields.
    function automatic logic [ADDR_W-1:0] br_target(input seq_word_t w);
        return {w.rs1, w.rs2};
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// 16x12 program store: synchronous write, asynchronous read.
module seq_prog_mem
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/branch/halt sequencer feeding a small microprocessor.
// Define SEQ_WATCHDOG_EN to build the 8-bit run-time watchdog.
module instruction_sequencer
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_wdata,
    input  logic              zero_flag,
    input  logic              carry_flag,
    output logic [OP_W-1:0]   instruction,
    output logic [SEL_W-1:0]  read_sel1,
    output logic [SEL_W-1:0]  read_sel2,
    output logic [SEL_W-1:0]  write_sel,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              timeout
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   instr_q, instr_d;
    logic [SEL_W-1:0]  rs1_q, rs1_d;
    logic [SEL_W-1:0]  rs2_q, rs2_d;
    logic [SEL_W-1:0]  rd_q, rd_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    seq_ctrl_e         br_ctrl_q, br_ctrl_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;

    logic [WORD_W-1:0] rdata;
    seq_word_t         fetch;
    logic              mem_we;
    logic              take;
    logic              stopped;

`ifdef SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic              wdog_hit;
`endif

    assign stopped = (state_q == S_IDLE) || (state_q == S_HALT);
    assign mem_we  = prog_we && stopped;
    assign fetch   = seq_word_t'(rdata);
    assign take    = (br_ctrl_q == CTRL_BZ) ? zero_flag : carry_flag;

    seq_prog_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc_q),
        .rdata (rdata)
    );

`ifdef SEQ_WATCHDOG_EN
    assign wdog_hit = !stopped && (wdog_q == WDOG_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        valid_d   = 1'b0;
        halted_d  = halted_q;
        br_ctrl_d = br_ctrl_q;
        br_tgt_d  = br_tgt_q;
`ifdef SEQ_WATCHDOG_EN
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
`endif

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d  = S_RUN;
                    pc_d     = '0;
                    halted_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
                    wdog_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                unique case (1'b1)
                    (fetch.ctrl == CTRL_NORMAL): begin
                        instr_d = fetch.op;
                        rs1_d   = fetch.rs1;
                        rs2_d   = fetch.rs2;
                        rd_d    = fetch.rd;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 4'd1;
                    end
                    (fetch.ctrl == CTRL_BZ),
                    (fetch.ctrl == CTRL_BC): begin
                        br_ctrl_d = fetch.ctrl;
                        br_tgt_d  = br_target(fetch);
                        state_d   = S_BR_WAIT;
                    end
                    (fetch.ctrl == CTRL_HALT): begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: state_d = S_RUN;
                endcase
            end
            S_BR_WAIT: begin
                pc_d    = take ? br_tgt_q : pc_q + 4'd1;
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SEQ_WATCHDOG_EN
        // Expiry overrides whatever the busy state would have done.
        if (wdog_hit) begin
            state_d   = S_HALT;
            pc_d      = pc_q;
            instr_d   = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            valid_d   = 1'b0;
            halted_d  = 1'b1;
            timeout_d = 1'b1;
        end else if (!stopped) begin
            wdog_d = wdog_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            br_ctrl_q <= CTRL_NORMAL;
            br_tgt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            br_ctrl_q <= br_ctrl_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign instruction = instr_q;
    assign read_sel1   = rs1_q;
    assign read_sel2   = rs2_q;
    assign write_sel   = rd_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized and directed checks of instruction_sequencer against a
// cycle-level reference model of the sequencing rules.
module tb_instruction_sequencer;

`ifdef SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BR   = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_wdata = '0;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic [3:0]  instruction;
    logic [1:0]  read_sel1, read_sel2, write_sel;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        halted;
    logic        timeout;

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .instruction (instruction),
        .read_sel1   (read_sel1),
        .read_sel2   (read_sel2),
        .write_sel   (write_sel),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .timeout     (timeout)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, program counter, mode and busy-cycle count.
    logic [11:0] m_mem [16];
    int          m_mode = M_IDLE;
    int          m_pc = 0;
    int          m_busy = 0;
    logic [11:0] m_br = '0;
    int e_valid = 0, e_pc = 0, e_halted = 0, e_timeout = 0;
    int e_instr = 0, e_s1 = 0, e_s2 = 0, e_ws = 0;
    bit e_care = 1'b0;

    always @(posedge clk) begin
        logic [11:0] w;
        int old_mode, old_pc;
        bit flag;
        w = m_mem[m_pc];
        old_mode = m_mode;
        old_pc = m_pc;
        if (prog_we && (m_mode == M_IDLE || m_mode == M_HALT))
            m_mem[prog_addr] = prog_wdata;
        e_valid = 0;
        e_care = 1'b0;
        if (!reset) begin
            m_mode = M_IDLE;
            m_pc = 0;
            e_halted = 0;
            e_timeout = 0;
            e_instr = 0; e_s1 = 0; e_s2 = 0; e_ws = 0;
            e_care = 1'b1;
        end else begin
            if (m_mode == M_IDLE || m_mode == M_HALT) begin
                if (start) begin
                    m_mode = M_RUN;
                    m_pc = 0;
                    m_busy = 0;
                    e_halted = 0;
                    e_timeout = 0;
                end
            end else if (m_mode == M_RUN) begin
                m_busy++;
                if (w[1:0] == 2'd0) begin
                    e_valid = 1;
                    e_instr = int'(w[11:8]);
                    e_s1 = int'(w[7:6]);
                    e_s2 = int'(w[5:4]);
                    e_ws = int'(w[3:2]);
                    e_care = 1'b1;
                    m_pc = (m_pc + 1) % 16;
                end else if (w[1:0] == 2'd3) begin
                    m_mode = M_HALT;
                    e_halted = 1;
                end else begin
                    m_br = w;
                    m_mode = M_BR;
                    e_instr = 0; e_s1 = 0; e_s2 = 0; e_ws = 0;
                    e_care = 1'b1;
                end
            end else begin
                m_busy++;
                flag = (m_br[1:0] == 2'd1) ? zero_flag : carry_flag;
                m_pc = flag ? int'(m_br[7:4]) : (m_pc + 1) % 16;
                m_mode = M_RUN;
            end
            if (WD && (old_mode == M_RUN || old_mode == M_BR) && m_busy == 255) begin
                m_mode = M_HALT;
                m_pc = old_pc;
                e_valid = 0;
                e_care = 1'b0;
                e_halted = 1;
                e_timeout = 1;
            end
        end
        e_pc = m_pc;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("instr_valid", 32'(instr_valid), 32'(e_valid));
            cmp("pc", 32'(pc), 32'(e_pc));
            cmp("halted", 32'(halted), 32'(e_halted));
            cmp("timeout", 32'(timeout), 32'(e_timeout));
            if (e_care) begin
                cmp("instruction", 32'(instruction), 32'(e_instr));
                cmp("read_sel1", 32'(read_sel1), 32'(e_s1));
                cmp("read_sel2", 32'(read_sel2), 32'(e_s2));
                cmp("write_sel", 32'(write_sel), 32'(e_ws));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [11:0] mk(input int op, input int r1, input int r2,
                                       input int rd, input int c);
        return {4'(op), 2'(r1), 2'(r2), 2'(rd), 2'(c)};
    endfunction

    task automatic load(input int a, input logic [11:0] w);
        prog_we = 1'b1;
        prog_addr = 4'(a);
        prog_wdata = w;
        step();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 40 && !halted; i++) step();
        cmp(nm, 32'(halted), 32'd1);
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        step();
        cmp("rst_pc", 32'(pc), 32'd0);
        cmp("rst_valid", 32'(instr_valid), 32'd0);
        cmp("rst_instr", 32'(instruction), 32'd0);
        reset = 1'b1;

        // Two normal ops then halt.
        load(0, mk(1, 3, 1, 0, 0));
        load(1, mk(2, 0, 1, 2, 0));
        load(2, mk(0, 0, 0, 0, 3));
        go();
        step();
        cmp("p1_valid", 32'(instr_valid), 32'd1);
        cmp("p1_instr", 32'(instruction), 32'd1);
        cmp("p1_rs1", 32'(read_sel1), 32'd3);
        step();
        cmp("p2_instr", 32'(instruction), 32'd2);
        cmp("p2_wsel", 32'(write_sel), 32'd2);
        step();
        cmp("p3_halted", 32'(halted), 32'd1);
        cmp("p3_pc", 32'(pc), 32'd2);
        cmp("p3_valid", 32'(instr_valid), 32'd0);

        // Branch-if-zero at 1 to target 5, taken then not taken.
        load(0, mk(3, 0, 0, 0, 0));
        load(1, mk(0, 1, 1, 0, 1));
        load(2, mk(4, 0, 0, 0, 0));
        load(3, mk(0, 0, 0, 0, 3));
        load(5, mk(7, 0, 0, 0, 0));
        load(6, mk(0, 0, 0, 0, 3));
        zero_flag = 1'b1;
        go();
        step();
        cmp("bz_first", 32'(instruction), 32'd3);
        step();
        cmp("bz_bubble1", 32'(instr_valid), 32'd0);
        cmp("bz_pc_hold", 32'(pc), 32'd1);
        step();
        cmp("bz_bubble2", 32'(instr_valid), 32'd0);
        cmp("bz_taken_pc", 32'(pc), 32'd5);
        step();
        cmp("bz_taken_instr", 32'(instruction), 32'd7);
        wait_halt("bz_halt1");
        zero_flag = 1'b0;
        go();
        step();
        step();
        step();
        cmp("bz_fall_pc", 32'(pc), 32'd2);
        step();
        cmp("bz_fall_instr", 32'(instruction), 32'd4);
        cmp("bz_fall_valid", 32'(instr_valid), 32'd1);
        wait_halt("bz_halt2");
        cmp("bz_halt_pc", 32'(pc), 32'd3);

        // Sixteen normal words; write to addr 3 while running is dropped.
        for (int i = 0; i < 16; i++) load(i, mk(i, 0, 0, 0, 0));
        go();
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) begin
                prog_we = 1'b1;
                prog_addr = 4'd3;
                prog_wdata = mk(9, 1, 1, 1, 0);
            end
            step();
            prog_we = 1'b0;
            cmp("wrap_valid", 32'(instr_valid), 32'd1);
            cmp("wrap_instr", 32'(instruction), 32'((k - 1) % 16));
            if (k == 16) cmp("wrap_pc", 32'(pc), 32'd0);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Reset in the middle of a branch, then memory retention.
        load(0, mk(0, 0, 0, 0, 2));
        carry_flag = 1'b1;
        go();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        cmp("brst_pc", 32'(pc), 32'd0);
        cmp("brst_valid", 32'(instr_valid), 32'd0);
        cmp("brst_halted", 32'(halted), 32'd0);
        cmp("brst_sel", 32'({read_sel1, read_sel2, write_sel, instruction}), 32'd0);
        go();
        step();
        cmp("mem_kept_valid", 32'(instr_valid), 32'd0);
        cmp("mem_kept_pc", 32'(pc), 32'd0);

        // Branch-to-self loop against the watchdog.
        for (int i = 0; i < 300; i++) step();
        cmp("wdog_timeout", 32'(timeout), 32'(WD));
        cmp("wdog_halted", 32'(halted), 32'(WD));
        carry_flag = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int c;
            c = int'($urandom_range(7, 0));
            reset = ($urandom_range(63, 0) != 0);
            start = ($urandom_range(7, 0) == 0);
            prog_we = ($urandom_range(2, 0) == 0);
            prog_addr = 4'($urandom_range(15, 0));
            prog_wdata = mk(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
                            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                            (c < 5) ? 0 : c - 4);
            zero_flag = 1'($urandom_range(1, 0));
            carry_flag = 1'($urandom_range(1, 0));
            step();
        end
        start = 1'b0;
        prog_we = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL: start  input  1  begin execution at pc 0 when IDLE or HALT.
REQ-004 SHALL: prog_we  input  1  program-memory write strobe.
REQ-005 SHALL: prog_addr  input  4  program-memory write address.
REQ-006 SHALL: prog_wdata  input  12  program word {opcode[11:8], rs1[7:6], rs2[5:4], rd[3:2], ctrl[1:0]}.
REQ-007 SHALL: zero_flag, carry_flag  input  1 each  ALU flags fed back from the downstream microprocessor.
REQ-008 SHALL: instruction  output  4  opcode to the microprocessor.
REQ-009 SHALL: read_sel1, read_sel2, write_sel  output  2 each  register selects to the microprocessor.
REQ-010 SHALL: instr_valid  output  1  outputs carry a real instruction this cycle.
REQ-011 SHALL: pc  output  4  address of the next word to fetch.
REQ-012 SHALL: halted  output  1  sequencer in HALT; timeout  output  1  watchdog expiry (see Configuration).

Function
REQ-013 SHALL: FSM states IDLE, RUN, BR_WAIT, HALT; all outputs registered.
REQ-014 SHALL: ctrl codes: 00 = normal op, 01 = branch-if-zero, 10 = branch-if-carry, 11 = halt; a branch target is word[7:4].
REQ-015 SHALL: IDLE or HALT with start=1 -> RUN next edge, pc<=0, halted<=0, timeout<=0.
REQ-016 SHALL: RUN with a normal word at mem[pc] -> instruction/selects <= word fields, instr_valid<=1, pc<=pc+1 (wraps 15->0), stay RUN.
REQ-017 SHALL: RUN with a branch word -> instr_valid<=0, instruction and selects <=0, pc unchanged, state<=BR_WAIT.
REQ-018 SHALL: BR_WAIT -> sample the selected flag; flag=1: pc<=target, otherwise pc<=pc+1; instr_valid<=0; state<=RUN. Each branch costs exactly 2 bubble cycles.
REQ-019 SHALL: RUN with a halt word -> instr_valid<=0, halted<=1, pc unchanged, state<=HALT.
REQ-020 SHALL: prog_we writes mem[prog_addr] only in IDLE or HALT; writes in RUN or BR_WAIT are ignored.
REQ-021 SHALL: simultaneous prog_we and start in IDLE/HALT -> the write completes and the start is accepted; the first fetch in RUN sees the new word.
REQ-022 SHALL: start is ignored in RUN and BR_WAIT.
REQ-023 SHALL: instr_valid=0 in IDLE, BR_WAIT and HALT; the downstream block treats invalid cycles as NOP.

Reset
REQ-024 SHALL: reset=0 at a rising edge -> state IDLE, pc=0, instruction=0, read_sel1=read_sel2=write_sel=0, instr_valid=0, halted=0, timeout=0, from any state including mid-branch.
REQ-025 SHALL: program memory contents are not altered by reset.

Configuration
REQ-026 SHALL: macro SEQ_WATCHDOG_EN defined -> an 8-bit counter clears on start, increments each RUN/BR_WAIT cycle, and on reaching 255 forces HALT with timeout<=1 and halted<=1.
REQ-027 SHALL: SEQ_WATCHDOG_EN undefined -> no counter is built and timeout is tied to 0.

Structure
REQ-028 SHALL: shared package seq_pkg holds the state enum, ctrl code constants, field bit positions, PROG_DEPTH=16 and WORD_W=12.
REQ-029 SHALL: sub-module seq_prog_mem holds the 16x12 array with a synchronous write and an asynchronous read at pc.

Verification
REQ-030 SHALL: load mem[0..2] = normal ops {op 1,3,1,0}, {op 2,0,1,2}, halt; start -> instr_valid=1 for 2 cycles with instruction 1 then 2, then halted=1, pc=2.
REQ-031 SHALL: mem[1] = branch-if-zero, target 5; zero_flag=1 in BR_WAIT -> next valid instruction is from mem[5]; repeat with zero_flag=0 -> fetch from mem[2].
REQ-032 SHALL: 16 normal words, no halt -> pc wraps 15->0 and instr_valid stays 1 continuously.
REQ-033 SHALL: assert reset=0 during BR_WAIT -> next cycle state IDLE, pc=0, all outputs 0; memory still holds the loaded program.
REQ-034 SHALL: prog_we to addr 3 while in RUN -> mem[3] unchanged when later fetched.
REQ-035 SHALL: with SEQ_WATCHDOG_EN, a branch-to-self loop -> timeout=1 and halted=1 after 255 RUN/BR_WAIT cycles; without the macro, timeout stays 0.
